// File: rtl/regfile_pkg.sv
// Shared core defines for the register file: ROB tag geometry and RV32 register constants.
// Other blocks of the core import this package so they agree on tag width.
package regfile_pkg;

    localparam int RF_ROB_WIDTH = 4;
    localparam int RF_ROB_SIZE  = 1 << RF_ROB_WIDTH;
    localparam int RF_REG_NUM   = 32;
    localparam int REG_ID_W     = 5;
    localparam int XLEN         = 32;

endpackage

// File: rtl/regfile_operand_lookup.sv
// Operand priority mux for one source register.
// Priority: x0, then the commit bypass, then the ROB search result, then a pending dependency, then the committed value.
module reg_operand_lookup
    import regfile_pkg::*;
#(
    parameter int ROB_WIDTH = RF_ROB_WIDTH
) (
    input  logic [REG_ID_W-1:0]  rs,
    input  logic                 reg_busy,
    input  logic [ROB_WIDTH-1:0] reg_tag,
    input  logic [XLEN-1:0]      reg_val,
    input  logic                 commit_ready,
    input  logic [ROB_WIDTH-1:0] commit_rob_id,
    input  logic [XLEN-1:0]      commit_val,
    input  logic                 search_ready,
    input  logic [XLEN-1:0]      search_val,
    output logic [XLEN-1:0]      op_val,
    output logic                 op_has_dep,
    output logic [ROB_WIDTH-1:0] op_dep
);

    always_comb begin
        // NOTE: every output gets a default before the if-chain so no path leaves one unassigned (no latch).
        op_val     = '0;
        op_has_dep = 1'b0;
        op_dep     = '0;
        if (rs != '0) begin
            if (reg_busy && commit_ready && (commit_rob_id == reg_tag)) begin
                op_val = commit_val;
            end else if (reg_busy && search_ready) begin
                op_val = search_val;
            end else if (reg_busy) begin
                op_has_dep = 1'b1;
                op_dep     = reg_tag;
            end else begin
                op_val = reg_val;
            end
        end
    end

endmodule

// File: rtl/regfile.sv
// Architectural register file with per-register rename state (busy bit + newest producer ROB tag).
// Answers two operand lookups per cycle, bypassing the commit port and the ROB search ports.
module regfile
    import regfile_pkg::*;
#(
    parameter int ROB_WIDTH = RF_ROB_WIDTH,
    parameter int REG_NUM   = RF_REG_NUM
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear,

    input  logic                 dec_ready,
    input  logic [4:0]           dec_rs1,
    input  logic [4:0]           dec_rs2,
    input  logic [4:0]           dec_rd,
    input  logic [ROB_WIDTH-1:0] dec_rob_id,

    output logic [31:0]          src1_val,
    output logic [31:0]          src2_val,
    output logic                 src1_has_dep,
    output logic                 src2_has_dep,
    output logic [ROB_WIDTH-1:0] src1_dep,
    output logic [ROB_WIDTH-1:0] src2_dep,

    output logic [ROB_WIDTH-1:0] search_rob_id_1,
    output logic [ROB_WIDTH-1:0] search_rob_id_2,
    input  logic                 search_ready_1,
    input  logic                 search_ready_2,
    input  logic [31:0]          search_val_1,
    input  logic [31:0]          search_val_2,

    input  logic                 commit_ready,
    input  logic [ROB_WIDTH-1:0] commit_rob_id,
    input  logic [4:0]           commit_reg_id,
    input  logic [31:0]          commit_val
);

    logic [XLEN-1:0]      reg_val  [REG_NUM];
    logic [ROB_WIDTH-1:0] reg_tag  [REG_NUM];
    logic [REG_NUM-1:0]   reg_busy;

    logic commit_we;
    logic issue_we;

    assign commit_we = commit_ready && (commit_reg_id != '0);
    assign issue_we  = dec_ready && (dec_rd != '0) && !clear;

    always_ff @(posedge clk_in or negedge rst_in) begin
        // NOTE: the storage array is reset in full because a mid-run reset must leave every register at zero.
        if (!rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                reg_val[i] <= '0;
                reg_tag[i] <= '0;
            end
            reg_busy <= '0;
        end else if (rdy_in) begin
            // NOTE: non-blocking assignments here, so the later issue/flush writes to busy win over the commit clear.
            if (commit_we) begin
                reg_val[commit_reg_id] <= commit_val;
                if (reg_busy[commit_reg_id] && (reg_tag[commit_reg_id] == commit_rob_id)) begin
                    reg_busy[commit_reg_id] <= 1'b0;
                end
            end
            if (clear) begin
                reg_busy <= '0;
            end else if (issue_we) begin
                reg_busy[dec_rd] <= 1'b1;
                reg_tag[dec_rd]  <= dec_rob_id;
            end
        end
    end

    // Lookups see pre-edge state, so an instruction reading its own rd gets the previous producer.
    assign search_rob_id_1 = reg_tag[dec_rs1];
    assign search_rob_id_2 = reg_tag[dec_rs2];

    reg_operand_lookup #(.ROB_WIDTH(ROB_WIDTH)) u_lookup_1 (
        .rs            (dec_rs1),
        .reg_busy      (reg_busy[dec_rs1]),
        .reg_tag       (reg_tag[dec_rs1]),
        .reg_val       (reg_val[dec_rs1]),
        .commit_ready  (commit_ready),
        .commit_rob_id (commit_rob_id),
        .commit_val    (commit_val),
        .search_ready  (search_ready_1),
        .search_val    (search_val_1),
        .op_val        (src1_val),
        .op_has_dep    (src1_has_dep),
        .op_dep        (src1_dep)
    );

    reg_operand_lookup #(.ROB_WIDTH(ROB_WIDTH)) u_lookup_2 (
        .rs            (dec_rs2),
        .reg_busy      (reg_busy[dec_rs2]),
        .reg_tag       (reg_tag[dec_rs2]),
        .reg_val       (reg_val[dec_rs2]),
        .commit_ready  (commit_ready),
        .commit_rob_id (commit_rob_id),
        .commit_val    (commit_val),
        .search_ready  (search_ready_2),
        .search_val    (search_val_2),
        .op_val        (src2_val),
        .op_has_dep    (src2_has_dep),
        .op_dep        (src2_dep)
    );

endmodule

// File: tb/tb_regfile.sv
// Directed testbench for regfile: rename, commit bypass, stale commit, flush, x0, stall and reset.
// Inputs change 1 time unit after each rising edge; outputs are sampled 1 unit later.
module tb_regfile;

    localparam int RW = 4;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          rdy_in;
    logic          clear;
    logic          dec_ready;
    logic [4:0]    dec_rs1, dec_rs2, dec_rd;
    logic [RW-1:0] dec_rob_id;
    logic [31:0]   src1_val, src2_val;
    logic          src1_has_dep, src2_has_dep;
    logic [RW-1:0] src1_dep, src2_dep;
    logic [RW-1:0] search_rob_id_1, search_rob_id_2;
    logic          search_ready_1, search_ready_2;
    logic [31:0]   search_val_1, search_val_2;
    logic          commit_ready;
    logic [RW-1:0] commit_rob_id;
    logic [4:0]    commit_reg_id;
    logic [31:0]   commit_val;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_in = ~clk_in;

    regfile #(.ROB_WIDTH(RW), .REG_NUM(32)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .clear           (clear),
        .dec_ready       (dec_ready),
        .dec_rs1         (dec_rs1),
        .dec_rs2         (dec_rs2),
        .dec_rd          (dec_rd),
        .dec_rob_id      (dec_rob_id),
        .src1_val        (src1_val),
        .src2_val        (src2_val),
        .src1_has_dep    (src1_has_dep),
        .src2_has_dep    (src2_has_dep),
        .src1_dep        (src1_dep),
        .src2_dep        (src2_dep),
        .search_rob_id_1 (search_rob_id_1),
        .search_rob_id_2 (search_rob_id_2),
        .search_ready_1  (search_ready_1),
        .search_ready_2  (search_ready_2),
        .search_val_1    (search_val_1),
        .search_val_2    (search_val_2),
        .commit_ready    (commit_ready),
        .commit_rob_id   (commit_rob_id),
        .commit_reg_id   (commit_reg_id),
        .commit_val      (commit_val)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        clear = 0; dec_ready = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0; dec_rob_id = 0;
        search_ready_1 = 0; search_ready_2 = 0; search_val_1 = 0; search_val_2 = 0;
        commit_ready = 0; commit_rob_id = 0; commit_reg_id = 0; commit_val = 0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [RW-1:0] rob);
        dec_ready = 1; dec_rd = rd; dec_rob_id = rob;
        tick();
        dec_ready = 0; dec_rd = 0; dec_rob_id = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rdy_in = 1;
        rst_in = 0;
        tick(); tick();
        rst_in = 1;
        dec_rs1 = 5; dec_rs2 = 31;
        #1;
        vectors++; if (src1_val !== 32'h0) begin miscompares++; $display("FAIL reset_src1_val got=%h exp=%h", src1_val, 32'h0); end
        vectors++; if (src1_has_dep !== 1'b0) begin miscompares++; $display("FAIL reset_src1_has_dep got=%b exp=0", src1_has_dep); end
        vectors++; if (src2_has_dep !== 1'b0) begin miscompares++; $display("FAIL reset_src2_has_dep got=%b exp=0", src2_has_dep); end
        vectors++; if (search_rob_id_1 !== 4'd0) begin miscompares++; $display("FAIL reset_search_id_1 got=%0d exp=0", search_rob_id_1); end
    endtask

    task automatic test_issue_lookup();
        idle_inputs();
        issue(5'd3, 4'd7);
        dec_rs1 = 3; dec_rs2 = 3;
        #1;
        vectors++; if (src1_has_dep !== 1'b1) begin miscompares++; $display("FAIL dep_has_dep got=%b exp=1", src1_has_dep); end
        vectors++; if (src1_dep !== 4'd7) begin miscompares++; $display("FAIL dep_tag got=%0d exp=7", src1_dep); end
        vectors++; if (src1_val !== 32'h0) begin miscompares++; $display("FAIL dep_val got=%h exp=0", src1_val); end
        vectors++; if (search_rob_id_1 !== 4'd7) begin miscompares++; $display("FAIL dep_search_id_1 got=%0d exp=7", search_rob_id_1); end
        vectors++; if (src2_dep !== 4'd7) begin miscompares++; $display("FAIL dep_src2_tag got=%0d exp=7", src2_dep); end
        search_ready_1 = 1; search_val_1 = 32'h55;
        #1;
        vectors++; if (src1_val !== 32'h55) begin miscompares++; $display("FAIL search_val got=%h exp=55", src1_val); end
        vectors++; if (src1_has_dep !== 1'b0 || src1_dep !== 4'd0) begin miscompares++; $display("FAIL search_nodep got=%b/%0d exp=0/0", src1_has_dep, src1_dep); end
        vectors++; if (src2_has_dep !== 1'b1) begin miscompares++; $display("FAIL search_port2_isolated got=%b exp=1", src2_has_dep); end
    endtask

    task automatic test_commit_bypass();
        idle_inputs();
        dec_rs1 = 3;
        commit_ready = 1; commit_rob_id = 7; commit_reg_id = 3; commit_val = 32'hABCD;
        search_ready_1 = 1; search_val_1 = 32'h1234;
        #1;
        vectors++; if (src1_val !== 32'hABCD) begin miscompares++; $display("FAIL bypass_val got=%h exp=abcd", src1_val); end
        vectors++; if (src1_has_dep !== 1'b0) begin miscompares++; $display("FAIL bypass_nodep got=%b exp=0", src1_has_dep); end
        tick();
        idle_inputs();
        dec_rs1 = 3;
        #1;
        vectors++; if (src1_val !== 32'hABCD) begin miscompares++; $display("FAIL committed_val got=%h exp=abcd", src1_val); end
        vectors++; if (src1_has_dep !== 1'b0) begin miscompares++; $display("FAIL committed_not_busy got=%b exp=0", src1_has_dep); end
    endtask

    task automatic test_stale_commit();
        idle_inputs();
        issue(5'd4, 4'd2);
        issue(5'd4, 4'd9);
        dec_rs1 = 4;
        commit_ready = 1; commit_rob_id = 2; commit_reg_id = 4; commit_val = 32'h11;
        #1;
        vectors++; if (src1_has_dep !== 1'b1 || src1_dep !== 4'd9) begin miscompares++; $display("FAIL stale_no_bypass got=%b/%0d exp=1/9", src1_has_dep, src1_dep); end
        tick();
        idle_inputs();
        dec_rs1 = 4;
        #1;
        vectors++; if (src1_has_dep !== 1'b1 || src1_dep !== 4'd9) begin miscompares++; $display("FAIL stale_still_busy got=%b/%0d exp=1/9", src1_has_dep, src1_dep); end
    endtask

    task automatic test_flush();
        idle_inputs();
        issue(5'd5, 4'd1);
        issue(5'd7, 4'd3);
        clear = 1;
        dec_ready = 1; dec_rd = 6; dec_rob_id = 12;
        commit_ready = 1; commit_rob_id = 3; commit_reg_id = 7; commit_val = 32'h77;
        tick();
        idle_inputs();
        dec_rs1 = 4; dec_rs2 = 6;
        #1;
        vectors++; if (src1_has_dep !== 1'b0 || src1_val !== 32'h11) begin miscompares++; $display("FAIL flush_x4 got=%b/%h exp=0/11", src1_has_dep, src1_val); end
        vectors++; if (src2_has_dep !== 1'b0 || search_rob_id_2 !== 4'd0) begin miscompares++; $display("FAIL flush_x6_not_renamed got=%b/%0d exp=0/0", src2_has_dep, search_rob_id_2); end
        dec_rs1 = 5; dec_rs2 = 7;
        #1;
        vectors++; if (src1_has_dep !== 1'b0 || src1_val !== 32'h0) begin miscompares++; $display("FAIL flush_x5 got=%b/%h exp=0/0", src1_has_dep, src1_val); end
        vectors++; if (src2_has_dep !== 1'b0 || src2_val !== 32'h77) begin miscompares++; $display("FAIL flush_commit_x7 got=%b/%h exp=0/77", src2_has_dep, src2_val); end
    endtask

    task automatic test_x0_self_dep();
        idle_inputs();
        issue(5'd0, 4'd4);
        commit_ready = 1; commit_rob_id = 4; commit_reg_id = 0; commit_val = 32'hDEAD;
        tick();
        idle_inputs();
        dec_rs1 = 0;
        #1;
        vectors++; if (src1_has_dep !== 1'b0 || src1_val !== 32'h0) begin miscompares++; $display("FAIL x0_zero got=%b/%h exp=0/0", src1_has_dep, src1_val); end
        vectors++; if (search_rob_id_1 !== 4'd0) begin miscompares++; $display("FAIL x0_tag got=%0d exp=0", search_rob_id_1); end
        issue(5'd8, 4'd5);
        dec_ready = 1; dec_rs1 = 8; dec_rd = 8; dec_rob_id = 10;
        #1;
        vectors++; if (src1_has_dep !== 1'b1 || src1_dep !== 4'd5) begin miscompares++; $display("FAIL self_dep_old_tag got=%b/%0d exp=1/5", src1_has_dep, src1_dep); end
        tick();
        idle_inputs();
        dec_rs1 = 8;
        #1;
        vectors++; if (src1_dep !== 4'd10) begin miscompares++; $display("FAIL self_dep_new_tag got=%0d exp=10", src1_dep); end
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        // Same-cycle commit of tag 10 and re-issue of x8 with tag 11: issue wins.
        commit_ready = 1; commit_rob_id = 10; commit_reg_id = 8; commit_val = 32'hAA;
        dec_ready = 1; dec_rd = 8; dec_rob_id = 11;
        tick();
        idle_inputs();
        dec_rs1 = 8;
        #1;
        vectors++; if (src1_has_dep !== 1'b1 || src1_dep !== 4'd11) begin miscompares++; $display("FAIL issue_over_commit got=%b/%0d exp=1/11", src1_has_dep, src1_dep); end
    endtask

    task automatic test_stall();
        idle_inputs();
        rdy_in = 0;
        dec_ready = 1; dec_rd = 9; dec_rob_id = 6;
        dec_rs1 = 8;
        commit_ready = 1; commit_rob_id = 11; commit_reg_id = 8; commit_val = 32'h99;
        #1;
        vectors++; if (src1_val !== 32'h99 || src1_has_dep !== 1'b0) begin miscompares++; $display("FAIL stall_comb_bypass got=%h/%b exp=99/0", src1_val, src1_has_dep); end
        tick();
        idle_inputs();
        rdy_in = 1;
        dec_rs1 = 8; dec_rs2 = 9;
        #1;
        vectors++; if (src1_has_dep !== 1'b1 || src1_dep !== 4'd11) begin miscompares++; $display("FAIL stall_no_commit got=%b/%0d exp=1/11", src1_has_dep, src1_dep); end
        vectors++; if (src2_has_dep !== 1'b0) begin miscompares++; $display("FAIL stall_no_issue got=%b exp=0", src2_has_dep); end
    endtask

    task automatic test_async_reset();
        idle_inputs();
        issue(5'd2, 4'd3);
        dec_rs1 = 2;
        #1;
        vectors++; if (src1_has_dep !== 1'b1) begin miscompares++; $display("FAIL pre_reset_busy got=%b exp=1", src1_has_dep); end
        rst_in = 0;
        #1;
        vectors++; if (src1_has_dep !== 1'b0 || search_rob_id_1 !== 4'd0) begin miscompares++; $display("FAIL async_reset got=%b/%0d exp=0/0", src1_has_dep, search_rob_id_1); end
        dec_rs1 = 3;
        #1;
        vectors++; if (src1_val !== 32'h0) begin miscompares++; $display("FAIL async_reset_val got=%h exp=0", src1_val); end
        tick();
        rst_in = 1;
    endtask

    initial begin
        test_reset();
        test_issue_lookup();
        test_commit_bypass();
        test_stale_commit();
        test_flush();
        test_x0_self_dep();
        test_back_to_back();
        test_stall();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile.md
# regfile

Architectural register file with register renaming for the out-of-order core. It holds the 32 committed RV32 register values and, per register, a busy bit plus the ROB tag of the newest in-flight producer. It answers operand lookups for the decoder/issue stage, querying the ROB for results that are still in flight. It is the receiving end of the ROB commit port and the requesting end of the ROB search port.

## Interface
Parameters:
- `ROB_WIDTH`, default 4: ROB tag width. Comes from the shared defines; `ROB_SIZE = 1 << ROB_WIDTH`.
- `REG_NUM`, default 32: number of architectural registers. x0 is hardwired to zero.

Ports:
- `clk_in` in 1: the single clock.
- `rst_in` in 1: asynchronous, active-low reset.
- `rdy_in` in 1: global ready. When low, all state holds.
- `clear` in 1: misprediction flush from the ROB.
- `dec_ready` in 1: an instruction is being issued this cycle.
- `dec_rs1`, `dec_rs2`, `dec_rd` in 5 each: source and destination register numbers.
- `dec_rob_id` in ROB_WIDTH: ROB tag allocated to the issuing instruction.
- `src1_val`, `src2_val` out 32: operand values.
- `src1_has_dep`, `src2_has_dep` out 1: the operand is still pending.
- `src1_dep`, `src2_dep` out ROB_WIDTH: ROB tag to wait on.
- `search_rob_id_1`, `search_rob_id_2` out ROB_WIDTH: tags sent to the ROB.
- `search_ready_1`, `search_ready_2` in 1: the ROB has a value for that tag.
- `search_val_1`, `search_val_2` in 32: value for that tag.
- `commit_ready` in 1: commit strobe, one cycle per commit.
- `commit_rob_id` in ROB_WIDTH: tag of the committing instruction.
- `commit_reg_id` in 5: destination register of the commit.
- `commit_val` in 32: committed value.

## Operation
State:
- `val[0..31]` (32 bits each).
- `busy[0..31]`.
- `tag[0..31]` (ROB_WIDTH bits each).

Operand lookup (combinational, identical for src1/src2; reads pre-clock-edge state):
- `search_rob_id_k = tag[dec_rsk]`.
- Priority order, first match wins:
  1. `dec_rsk == 0`: val 0, no dependency.
  2. `busy` set, `commit_ready` high, and `commit_rob_id == tag`: `commit_val`, no dependency.
  3. `busy` set and `search_ready_k` high: `search_val_k`, no dependency.
  4. `busy` set: `has_dep = 1`, `dep = tag`, val 0.
  5. Otherwise: `val[dec_rsk]`, no dependency.
- `src*_dep` is 0 whenever `has_dep` is 0.

Clocked update (only when `rdy_in` is high):
- Commit, when `commit_ready` is high and `commit_reg_id != 0`:
  - `val[commit_reg_id] <= commit_val`.
  - If `busy` is set and `tag == commit_rob_id`, clear `busy`.
- Issue, when `dec_ready` is high, `dec_rd != 0`, and `clear` is low:
  - `busy[dec_rd] <= 1`, `tag[dec_rd] <= dec_rob_id`.
  - Issue overrides a same-cycle commit busy-clear on the same register.
- Flush, when `clear` is high:
  - Clear all `busy` bits; `val` is untouched.
  - A commit in the same cycle still writes `val`.
  - Issue in that cycle is ignored.

Boundary rules:
- Register x0 is never written and never busy.
- An instruction reading its own rd (e.g. `add x1,x1,x1`) sees the previous producer's tag, not its own.
- A commit whose tag no longer matches (the register was renamed again) updates `val` but leaves `busy`/`tag` unchanged.
- Mid-operation reset: all state clears immediately and asynchronously.

## Timing
- Reset (`rst_in` low): all `val` = 0, `busy` = 0, `tag` = 0.
  - With the issue inputs at 0, all `src*` outputs are 0 and `has_dep` is 0.
  - `search_rob_id_*` are 0.
- Lookup latency is 0 cycles: outputs are valid in the same cycle as `dec_rs*`.
- Commit in cycle N is visible through the bypass in cycle N, and through `val` from cycle N+1.
- Issue rename in cycle N is visible to lookups from cycle N+1.
- Flush in cycle N: lookups in cycle N+1 see no dependencies.
- `rdy_in` low freezes all state; the combinational outputs still track their inputs.

## Structure
- `ROB_WIDTH` and `ROB_SIZE` come from the shared defines header; the RV32 register count constant goes there too.
- One sub-module, `reg_operand_lookup`: the priority mux for one operand. It is instantiated twice, taking state slices, the commit bypass and one search port.
- Total 150–250 lines.

## Test plan
- **Reset, then read:** read x5 → `src1_val` = 0, `has_dep` = 0.
- **Issue, then read before commit:**
  - Issue `rd=3`, `rob_id=7`; next cycle read x3 with `search_ready_1=0` → `has_dep` = 1, `dep` = 7, `search_rob_id_1` = 7.
  - Same read with `search_ready_1=1`, `search_val_1=0x55` → val 0x55, no dependency.
- **Commit bypass:** x3 busy with tag 7; commit (7, x3, 0xABCD) while reading x3 → `src1_val` = 0xABCD, no dependency. Next cycle `busy[3]` = 0 and `val[3]` = 0xABCD.
- **Stale commit:** issue x4 with tag 2, then x4 with tag 9; commit (2, x4, 0x11) → `val[4]` = 0x11, x4 still dependent on tag 9.
- **Flush:** three registers busy; `clear`=1 with a same-cycle issue to x6 → next cycle no register busy, x6 not renamed.
- **x0 and self-dependency:**
  - Issue `rd=0` → x0 never busy.
  - Issue `rs1=rd=8` (x8 previously tagged 5) with `rob_id` 10 → `src1_dep` = 5; afterwards `tag[8]` = 10.
